ntt_twiddle_sequencer: RTL and testbench
========================================

# ntt_twiddle_sequencer

Address and control sequencer that walks the twiddle-factor ROM for a full 256-point forward or inverse NTT. It drives the dual-port twiddle ROM with two twiddle indices per cycle, one for each of two butterfly units. It then realigns the ROM's one-cycle registered read with valid, layer and last flags for the butterfly datapath downstream. It sits between the polynomial-arithmetic controller (start/done handshake) and the twiddle ROM.

## Interface
Parameters:
- LOGN, 8, log2 of the transform size. 256 coefficients, 8 layers, 128 butterflies per layer.
- ADDR_W, 8, ROM address width. Must equal LOGN.
- LAYER_GAP, 4, idle cycles inserted between consecutive layers for butterfly-pipeline drain. Legal range 0..15.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- start  in  1  pulse that starts a transform. Sampled only in IDLE.
- inv  in  1  mode select, sampled with start. 0 = forward NTT, 1 = inverse NTT.
- hold  in  1  downstream back-pressure. Freezes the whole sequencer.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- rom_en  out  1  ROM read enable.
- rom_addra, rom_addrb  out  ADDR_W  twiddle indices for butterfly units 0 and 1.
- tw_valid  out  1  ROM data outputs hold a valid twiddle pair this cycle.
- tw_layer  out  3  layer index of the pair on the ROM outputs.
- tw_last  out  1  the pair on the ROM outputs is the final pair of the transform.
- tw_inv  out  1  latched mode, for sign handling downstream.

## Operation
- **States:** IDLE → RUN → (GAP → RUN)* → FLUSH → IDLE.
- **IDLE:** start=1 latches inv into tw_inv, clears the layer counter l and the pair counter c (6 bits, 0..63), and enters RUN.
- **RUN:**
  - Each non-held cycle issues the pair c of layer l with rom_en=1.
  - Butterfly indices are b0=2c and b1=2c+1.
  - Group index is g = b >> (7−l).
  - Forward address: (1<<l) + g. Layer l uses order l = 0..7.
  - Inverse address: (1<<(l+1)) − 1 − g. Layer l uses order l = 7 down to 0.
  - All arithmetic is ADDR_W-bit unsigned, with no wrap in the legal range.
  - After c=63:
    - if the current layer is not the final one and LAYER_GAP>0, go to GAP;
    - if the current layer is not the final one and LAYER_GAP=0, go directly to the next layer's c=0;
    - after the final layer, go to FLUSH.
- **GAP:** rom_en=0. A gap counter runs for LAYER_GAP cycles, then the FSM enters RUN for the next layer.
- **FLUSH:** rom_en=0. Waits for the final ROM read to emerge with tw_valid=1 and tw_last=1. The next non-held cycle pulses done, deasserts busy, and returns to IDLE.
- **hold=1:**
  - rom_en is forced to 0.
  - All counters, the state, tw_valid, tw_layer and tw_last are frozen.
  - The ROM outputs stay stable because its enable is low, so downstream sees the same pair until hold drops.
- **start outside IDLE** is ignored. inv changes mid-transform are ignored.
- **Reset (any time, including mid-transform):** state=IDLE and counters=0. All outputs are 0: busy, done, rom_en, rom_addra, rom_addrb, tw_valid, tw_layer, tw_last and tw_inv.

## Timing
- rom_en, rom_addra and rom_addrb are registered. With start sampled at cycle 0, the first pair is issued at cycle 1.
- tw_valid, tw_layer and tw_last are rom_en, the layer and the last-pair condition delayed by one non-held cycle. They align with the ROM data outputs.
- Without hold, the issue cycles per layer are:
  - layer k, forward order: cycles 1+k·(64+LAYER_GAP) through 64+k·(64+LAYER_GAP);
  - last issue cycle: 8·64 + 7·LAYER_GAP;
  - final tw_valid: one cycle after the last issue cycle;
  - done: one cycle after the final tw_valid.
  - With the default LAYER_GAP=4: last issue at cycle 540, final tw_valid at 541, done at 542.
- Each hold cycle adds exactly one cycle to every later event. Throughput is two twiddles per non-held RUN cycle.
- done coincides with busy falling. A start in the done cycle is ignored. A start in the next cycle is accepted.

## Test plan
- **Forward, LAYER_GAP=4:** start inv=0 at cycle 0.
  - Cycle 1: (addra, addrb) = (1, 1).
  - First layer-1 pair at cycle 69: (2, 2).
  - First layer-7 pair at cycle 477: (128, 129).
  - Last pair at cycle 540: (254, 255).
  - tw_last at cycle 541, done at 542, 512 rom_en cycles in total.
- **Inverse:** start inv=1.
  - First pair: (255, 254) with tw_layer=7.
  - Layer-0 pairs all (1, 1).
  - tw_inv=1 throughout.
- **LAYER_GAP=0:** rom_en is high for 512 contiguous cycles (cycles 1..512), and done arrives at cycle 514.
- **Hold:** assert hold for 3 cycles at cycle 10.
  - rom_en=0 during the hold.
  - tw_valid and the ROM data are unchanged during the hold.
  - No pair is skipped or duplicated.
  - done arrives at cycle 545.
- **Reset mid-transform:** assert rst at cycle 200.
  - All outputs go to 0 immediately.
  - A subsequent start reproduces the scenario-1 sequence from cycle 1.
- **start while busy:** ignored, with no effect on the address sequence or on done timing.

Source files
------------

// File: rtl/ntt_twiddle_sequencer.sv
// Twiddle-ROM address sequencer for a 2^LOGN-point forward/inverse NTT.
// Issues two twiddle indices per cycle, one per butterfly unit. It then
// realigns valid/layer/last with the one-cycle registered ROM read.
module ntt_twiddle_sequencer #(
  parameter int LOGN      = 8,
  parameter int ADDR_W    = 8,
  parameter int LAYER_GAP = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      inv,
  input  logic                      hold,
  output logic                      busy,
  output logic                      done,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addra,
  output logic [ADDR_W-1:0]         rom_addrb,
  output logic                      tw_valid,
  output logic [$clog2(LOGN)-1:0]   tw_layer,
  output logic                      tw_last,
  output logic                      tw_inv
);

  localparam int LW = $clog2(LOGN);
  localparam int PW = LOGN - 2;
  localparam logic [LW-1:0]   TOP_LAYER = LW'(LOGN - 1);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);
  localparam logic [3:0]      GAP_END   = 4'(LAYER_GAP - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]    state, nxt_state;
  logic [LW-1:0] l, nxt_l;
  logic [PW-1:0] c, nxt_c;
  logic [3:0]    gcnt, nxt_gcnt;
  logic          nxt_busy, nxt_done, nxt_inv;
  logic          issue, issue_p0;
  logic          last_layer;
  logic [LW-1:0] step_l;

  // Twiddle index for butterfly b of layer lyr. The extra bit keeps 2^(lyr+1)
  // representable on the top inverse layer before the final truncation.
  function automatic logic [ADDR_W-1:0] twiddle_addr(
    input logic [LW-1:0]   lyr,
    input logic [LOGN-2:0] b,
    input logic            inverse
  );
    logic [ADDR_W:0] span;
    logic [ADDR_W:0] grp;
    span = ONE << lyr;
    grp  = (ADDR_W + 1)'(b >> (TOP_LAYER - lyr));
    if (inverse) twiddle_addr = ADDR_W'((span << 1) - ONE - grp);
    else         twiddle_addr = ADDR_W'(span + grp);
  endfunction

  assign last_layer = tw_inv ? (l == '0) : (l == TOP_LAYER);
  assign step_l     = tw_inv ? (l - 1'b1) : (l + 1'b1);
  assign rom_en     = issue_p0 & ~hold;

  // Next-state and counter update; 'issue' marks a pair to register this edge.
  always_comb begin
    nxt_state = state;
    nxt_l     = l;
    nxt_c     = c;
    nxt_gcnt  = gcnt;
    nxt_busy  = busy;
    nxt_done  = 1'b0;
    nxt_inv   = tw_inv;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done) begin
          nxt_state = S_RUN;
          nxt_inv   = inv;
          nxt_l     = inv ? TOP_LAYER : '0;
          nxt_c     = '0;
          nxt_busy  = 1'b1;
          issue     = 1'b1;
        end
      end
      S_RUN: begin
        if (&c) begin
          if (last_layer) begin
            nxt_state = S_FLUSH;
          end else if (LAYER_GAP == 0) begin
            nxt_l = step_l;
            nxt_c = '0;
            issue = 1'b1;
          end else begin
            nxt_state = S_GAP;
            nxt_gcnt  = '0;
          end
        end else begin
          nxt_c = c + 1'b1;
          issue = 1'b1;
        end
      end
      S_GAP: begin
        if (gcnt == GAP_END) begin
          nxt_state = S_RUN;
          nxt_l     = step_l;
          nxt_c     = '0;
          issue     = 1'b1;
        end else begin
          nxt_gcnt = gcnt + 1'b1;
        end
      end
      default: begin
        if (tw_valid && tw_last) begin
          nxt_state = S_IDLE;
          nxt_done  = 1'b1;
          nxt_busy  = 1'b0;
        end
      end
    endcase
  end

  // Sequencer registers; hold freezes everything except the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      l         <= '0;
      c         <= '0;
      gcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tw_inv    <= 1'b0;
      issue_p0  <= 1'b0;
      rom_addra <= '0;
      rom_addrb <= '0;
      tw_valid  <= 1'b0;
      tw_layer  <= '0;
      tw_last   <= 1'b0;
    end else begin
      done <= hold ? 1'b0 : nxt_done;
      if (!hold) begin
        state    <= nxt_state;
        l        <= nxt_l;
        c        <= nxt_c;
        gcnt     <= nxt_gcnt;
        busy     <= nxt_busy;
        tw_inv   <= nxt_inv;
        issue_p0 <= issue;
        if (issue) begin
          rom_addra <= twiddle_addr(nxt_l, {nxt_c, 1'b0}, nxt_inv);
          rom_addrb <= twiddle_addr(nxt_l, {nxt_c, 1'b1}, nxt_inv);
        end
        // ---- stage boundary: ROM read, flags follow the issued pair ----
        tw_valid <= issue_p0;
        tw_layer <= l;
        tw_last  <= issue_p0 && last_layer && (&c);
      end
    end
  end

endmodule

// File: tb/tb_ntt_twiddle_sequencer.sv
// Scoreboard bench for ntt_twiddle_sequencer: forward, inverse, hold,
// reset-abort and start-while-busy scenarios, plus a LAYER_GAP=0 instance.
module tb_ntt_twiddle_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, inv, hold;
  logic       busy, done, rom_en, tw_valid, tw_last, tw_inv;
  logic [7:0] rom_addra, rom_addrb;
  logic [2:0] tw_layer;

  logic       start0;
  logic       busy0, done0, rom_en0, tw_valid0, tw_last0, tw_inv0;
  logic [7:0] rom_addra0, rom_addrb0;
  logic [2:0] tw_layer0;
  logic       zero = 1'b0;

  ntt_twiddle_sequencer #(.LOGN(8), .ADDR_W(8), .LAYER_GAP(4)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv), .hold(hold),
    .busy(busy), .done(done), .rom_en(rom_en),
    .rom_addra(rom_addra), .rom_addrb(rom_addrb),
    .tw_valid(tw_valid), .tw_layer(tw_layer), .tw_last(tw_last), .tw_inv(tw_inv)
  );

  ntt_twiddle_sequencer #(.LOGN(8), .ADDR_W(8), .LAYER_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .inv(zero), .hold(zero),
    .busy(busy0), .done(done0), .rom_en(rom_en0),
    .rom_addra(rom_addra0), .rom_addrb(rom_addrb0),
    .tw_valid(tw_valid0), .tw_layer(tw_layer0), .tw_last(tw_last0), .tw_inv(tw_inv0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int a; int b; } pair_t;
  typedef struct { int layer; int last; int inverse; } meta_t;
  typedef struct { int at; int a; int b; } spot_t;

  pair_t pq[$];
  meta_t vq[$];
  int    dq[$];
  spot_t sq[$];
  bit    track = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    t0 = 0;

  function void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endfunction

  // Expected pair stream straight from the twiddle-index definition.
  task automatic push_model(input bit inverse);
    for (int k = 0; k < 8; k++) begin
      int l;
      l = inverse ? 7 - k : k;
      for (int c = 0; c < 64; c++) begin
        pair_t p;
        meta_t m;
        int g0, g1;
        g0 = ((2 * c) * (1 << l)) / 128;
        g1 = ((2 * c + 1) * (1 << l)) / 128;
        p.a = inverse ? (2 << l) - 1 - g0 : (1 << l) + g0;
        p.b = inverse ? (2 << l) - 1 - g1 : (1 << l) + g1;
        m.layer = l;
        m.last = (k == 7 && c == 63) ? 1 : 0;
        m.inverse = inverse ? 1 : 0;
        pq.push_back(p);
        vq.push_back(m);
      end
    end
  endtask

  task automatic add_spot(input int at, input int a, input int b);
    spot_t s;
    s.at = at; s.a = a; s.b = b;
    sq.push_back(s);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rel(input int r);
    while (cyc - t0 < r) tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rom_en"}, int'(rom_en), 0);
    chk({tag, "_addra"}, int'(rom_addra), 0);
    chk({tag, "_addrb"}, int'(rom_addrb), 0);
    chk({tag, "_tw_valid"}, int'(tw_valid), 0);
    chk({tag, "_tw_layer"}, int'(tw_layer), 0);
    chk({tag, "_tw_last"}, int'(tw_last), 0);
    chk({tag, "_tw_inv"}, int'(tw_inv), 0);
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  logic       hold_d = 1'b0;
  logic       tv_d = 1'b0;
  logic [2:0] tl_d = '0;
  always @(negedge clk) begin
    if (track && rom_en) begin
      if (pq.size() == 0) chk("extra_pair", 1, 0);
      else begin
        pair_t p;
        p = pq.pop_front();
        chk("addra", int'(rom_addra), p.a);
        chk("addrb", int'(rom_addrb), p.b);
      end
    end
    if (track && tw_valid && !hold) begin
      if (vq.size() == 0) chk("extra_valid", 1, 0);
      else begin
        meta_t m;
        m = vq.pop_front();
        chk("tw_layer", int'(tw_layer), m.layer);
        chk("tw_last", int'(tw_last), m.last);
        chk("tw_inv", int'(tw_inv), m.inverse);
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("extra_done", 1, 0);
      else chk("done_cycle", cyc, dq.pop_front());
      chk("busy_at_done", int'(busy), 0);
    end
    if (sq.size() > 0 && sq[0].at == cyc) begin
      spot_t s;
      s = sq.pop_front();
      chk("spot_en", int'(rom_en), 1);
      chk("spot_addra", int'(rom_addra), s.a);
      chk("spot_addrb", int'(rom_addrb), s.b);
    end
    if (hold) chk("rom_en_in_hold", int'(rom_en), 0);
    if (hold_d) begin
      chk("valid_frozen", int'(tw_valid), int'(tv_d));
      chk("layer_frozen", int'(tw_layer), int'(tl_d));
    end
    hold_d <= hold;
    tv_d   <= tw_valid;
    tl_d   <= tw_layer;
  end

  initial begin
    int first, last, cnt, drel, rel;
    rst = 1'b1; start = 1'b0; inv = 1'b0; hold = 1'b0; start0 = 1'b0;
    tick();
    #1 check_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // Forward run, with a stray start mid-run and one on the done cycle.
    track = 1'b1;
    t0 = cyc; start = 1'b1; inv = 1'b0;
    push_model(1'b0);
    dq.push_back(t0 + 542);
    add_spot(t0 + 1, 1, 1);
    add_spot(t0 + 69, 2, 2);
    add_spot(t0 + 477, 128, 129);
    add_spot(t0 + 540, 254, 255);
    tick(); start = 1'b0;
    wait_rel(100); start = 1'b1; inv = 1'b1;
    tick(); start = 1'b0; inv = 1'b0;
    wait_rel(542); start = 1'b1; inv = 1'b1;
    tick();

    // Inverse run, started the cycle after done.
    t0 = cyc;
    push_model(1'b1);
    dq.push_back(t0 + 542);
    add_spot(t0 + 1, 255, 254);
    tick(); start = 1'b0; inv = 1'b0;
    wait_rel(546);

    // Forward run with a 3-cycle hold at cycle 10.
    t0 = cyc; start = 1'b1; inv = 1'b0;
    push_model(1'b0);
    dq.push_back(t0 + 545);
    add_spot(t0 + 9, 1, 1);
    add_spot(t0 + 13, 1, 1);
    tick(); start = 1'b0;
    wait_rel(10); hold = 1'b1;
    wait_rel(13); hold = 1'b0;
    wait_rel(549);

    // Inverse run aborted by reset, then a clean forward rerun.
    track = 1'b0;
    t0 = cyc; start = 1'b1; inv = 1'b1;
    tick(); start = 1'b0; inv = 1'b0;
    wait_rel(200);
    chk("busy_before_abort", int'(busy), 1);
    chk("inv_before_abort", int'(tw_inv), 1);
    rst = 1'b1;
    #1 check_zero("abort");
    tick(); rst = 1'b0;
    tick();
    track = 1'b1;
    t0 = cyc; start = 1'b1; inv = 1'b0;
    push_model(1'b0);
    dq.push_back(t0 + 542);
    add_spot(t0 + 1, 1, 1);
    add_spot(t0 + 540, 254, 255);
    tick(); start = 1'b0;
    wait_rel(546);

    // LAYER_GAP=0 instance: one contiguous burst of 512 issues.
    t0 = cyc; start0 = 1'b1;
    tick(); start0 = 1'b0;
    first = -1; last = -1; cnt = 0; drel = -1;
    for (int i = 0; i < 530; i++) begin
      rel = cyc - t0;
      if (rom_en0) begin
        if (first < 0) first = rel;
        last = rel;
        cnt++;
      end
      if (done0 && drel < 0) drel = rel;
      tick();
    end
    chk("gap0_first_issue", first, 1);
    chk("gap0_last_issue", last, 512);
    chk("gap0_issue_count", cnt, 512);
    chk("gap0_done_cycle", drel, 514);

    chk("pairs_left", pq.size(), 0);
    chk("valids_left", vq.size(), 0);
    chk("dones_left", dq.size(), 0);
    chk("spots_left", sq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
